// File: rtl/rob_pkg.sv
// ============================================================================
//  Module      : rob_pkg
//  Description : Shared types, default sizes and helpers for the rob_multiway
//                reorder buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rob_pkg;

   localparam int c_ROB_DEPTH = 32;
   localparam int c_DISP_W    = 2;
   localparam int c_RET_W     = 2;
   localparam int c_CDB_W     = 2;
   localparam int c_XLEN      = 32;
   localparam int c_REG_BITS  = 5;
   localparam int c_TAG_BITS  = $clog2(c_ROB_DEPTH);

   typedef logic [c_TAG_BITS-1:0] rob_tag_t;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic                  mispred;
      logic [c_REG_BITS-1:0] dest_idx;
      logic [c_XLEN-1:0]     value;
   } rob_entry_t;

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rob_slot.sv
// ============================================================================
//  Module      : rob_slot
//  Description : One reorder-buffer entry: allocate, complete, mark mispredict,
//                clear. Clear has priority over every other update.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_slot
   import rob_pkg::*;
#(
   parameter int XLEN     = c_XLEN,
   parameter int REG_BITS = c_REG_BITS
)(
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                alloc,
   input  logic [REG_BITS-1:0] alloc_dest,
   input  logic                complete,
   input  logic [XLEN-1:0]     complete_value,
   input  logic                mispredict,
   output logic                busy,
   output logic                done,
   output logic                mispred,
   output logic [REG_BITS-1:0] dest_idx,
   output logic [XLEN-1:0]     value
);

   logic                r_busy;
   logic                r_done;
   logic                r_mispred;
   logic [REG_BITS-1:0] r_dest;
   logic [XLEN-1:0]     r_value;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mispred <= 1'b0;
         r_dest    <= '0;
         r_value   <= '0;
      end else if (alloc) begin
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
         r_mispred <= 1'b0;
         r_dest    <= alloc_dest;
      end else if (r_busy) begin
         if (complete) begin
            r_done  <= 1'b1;
            r_value <= complete_value;
         end
         if (mispredict) begin
            r_mispred <= 1'b1;
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign mispred  = r_mispred;
   assign dest_idx = r_dest;
   assign value    = r_value;

endmodule

`default_nettype wire

// File: rtl/rob_multiway.sv
// ============================================================================
//  Module      : rob_multiway
//  Description : Superscalar reorder buffer with in-order multi-lane retire and
//                squash on retirement of a mispredicted branch.
//                Define ROB_CDB_BYPASS_EN for same-cycle CDB-to-retire bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_multiway
   import rob_pkg::*;
#(
   parameter int ROB_DEPTH = c_ROB_DEPTH,
   parameter int DISP_W    = c_DISP_W,
   parameter int RET_W     = c_RET_W,
   parameter int CDB_W     = c_CDB_W,
   parameter int XLEN      = c_XLEN,
   parameter int REG_BITS  = c_REG_BITS
)(
   input  logic                                clock,
   input  logic                                reset,
   input  logic [DISP_W-1:0]                   disp_valid,
   input  logic [DISP_W*REG_BITS-1:0]          disp_dest_idx,
   output logic [$clog2(DISP_W+1)-1:0]         disp_avail,
   output logic [DISP_W*$clog2(ROB_DEPTH)-1:0] disp_tag,
   input  logic [CDB_W-1:0]                    cdb_valid,
   input  logic [CDB_W*$clog2(ROB_DEPTH)-1:0]  cdb_tag,
   input  logic [CDB_W*XLEN-1:0]               cdb_value,
   input  logic                                mispredict_valid,
   input  logic [$clog2(ROB_DEPTH)-1:0]        mispredict_tag,
   output logic [RET_W-1:0]                    ret_valid,
   output logic [RET_W*REG_BITS-1:0]           ret_dest_idx,
   output logic [RET_W*XLEN-1:0]               ret_value,
   output logic                                squash,
   output logic [$clog2(ROB_DEPTH+1)-1:0]      count,
   output logic                                full,
   output logic                                empty
);

   localparam int c_TAG_W = $clog2(ROB_DEPTH);
   localparam int c_CNT_W = $clog2(ROB_DEPTH+1);
   localparam int c_AV_W  = $clog2(DISP_W+1);

   logic [c_TAG_W-1:0]  r_head;
   logic [c_TAG_W-1:0]  r_tail;
   logic [c_CNT_W-1:0]  r_count;

   logic [ROB_DEPTH-1:0] w_busy;
   logic [ROB_DEPTH-1:0] w_done;
   logic [ROB_DEPTH-1:0] w_mispred;
   logic [ROB_DEPTH-1:0] w_alloc;
   logic [ROB_DEPTH-1:0] w_complete;
   logic [ROB_DEPTH-1:0] w_mark_mp;
   logic [ROB_DEPTH-1:0] w_retire;
   logic [REG_BITS-1:0]  w_dest       [ROB_DEPTH];
   logic [REG_BITS-1:0]  w_alloc_dest [ROB_DEPTH];
   logic [XLEN-1:0]      w_value      [ROB_DEPTH];
   logic [XLEN-1:0]      w_cmp_value  [ROB_DEPTH];
   int                   w_n_alloc;
   int                   w_n_ret;
   logic                 w_squash;

   assign count      = r_count;
   assign full       = (r_count == c_CNT_W'(ROB_DEPTH));
   assign empty      = (r_count == '0);
   assign squash     = w_squash;
   // Slots freed by this cycle's retires only become visible next cycle.
   assign disp_avail = c_AV_W'(min_int(DISP_W, ROB_DEPTH - int'(r_count)));

   always_comb begin : p_dispatch
      logic [c_TAG_W-1:0] v_tag;
      v_tag     = '0;
      w_alloc   = '0;
      w_n_alloc = 0;
      disp_tag  = '0;
      for (int k = 0; k < ROB_DEPTH; k++) w_alloc_dest[k] = '0;
      for (int i = 0; i < DISP_W; i++) begin
         v_tag = r_tail + c_TAG_W'(i);
         disp_tag[i*c_TAG_W +: c_TAG_W] = v_tag;
         if (disp_valid[i] && (i < int'(disp_avail)) && !w_squash && !reset) begin
            w_alloc[v_tag]      = 1'b1;
            w_alloc_dest[v_tag] = disp_dest_idx[i*REG_BITS +: REG_BITS];
            w_n_alloc           = w_n_alloc + 1;
         end
      end
   end

   always_comb begin : p_complete
      logic [c_TAG_W-1:0] v_tag;
      v_tag      = '0;
      w_complete = '0;
      w_mark_mp  = '0;
      for (int k = 0; k < ROB_DEPTH; k++) w_cmp_value[k] = '0;
      for (int c = 0; c < CDB_W; c++) begin
         v_tag = cdb_tag[c*c_TAG_W +: c_TAG_W];
         if (cdb_valid[c] && w_busy[v_tag] && !w_squash) begin
            w_complete[v_tag]  = 1'b1;
            w_cmp_value[v_tag] = cdb_value[c*XLEN +: XLEN];
         end
      end
      if (mispredict_valid && !w_squash) w_mark_mp[mispredict_tag] = 1'b1;
   end

   // Scan stops at the first non-eligible entry or right after a mispredict.
   always_comb begin : p_retire
      logic [c_TAG_W-1:0] v_idx;
      logic               v_chain;
      logic               v_elig;
      logic [XLEN-1:0]    v_val;
      v_idx        = '0;
      v_chain      = 1'b1;
      v_elig       = 1'b0;
      v_val        = '0;
      ret_valid    = '0;
      ret_dest_idx = '0;
      ret_value    = '0;
      w_retire     = '0;
      w_n_ret      = 0;
      w_squash     = 1'b0;
      for (int j = 0; j < RET_W; j++) begin
         v_idx  = r_head + c_TAG_W'(j);
         v_elig = w_busy[v_idx] && w_done[v_idx];
         v_val  = w_value[v_idx];
`ifdef ROB_CDB_BYPASS_EN
         for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && (cdb_tag[c*c_TAG_W +: c_TAG_W] == v_idx)) begin
               v_elig = w_busy[v_idx];
               v_val  = cdb_value[c*XLEN +: XLEN];
            end
         end
`endif
         if (v_chain && v_elig && !reset) begin
            ret_valid[j]                        = 1'b1;
            ret_dest_idx[j*REG_BITS +: REG_BITS] = w_dest[v_idx];
            ret_value[j*XLEN +: XLEN]           = v_val;
            w_retire[v_idx]                     = 1'b1;
            w_n_ret                             = w_n_ret + 1;
            if (w_mispred[v_idx]) begin
               w_squash = 1'b1;
               v_chain  = 1'b0;
            end
         end else begin
            v_chain = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || w_squash) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + c_TAG_W'(w_n_ret);
         r_tail  <= r_tail + c_TAG_W'(w_n_alloc);
         r_count <= c_CNT_W'(int'(r_count) + w_n_alloc - w_n_ret);
      end
   end

   generate
      for (genvar k = 0; k < ROB_DEPTH; k++) begin : g_slot
         rob_slot #(
            .XLEN     (XLEN),
            .REG_BITS (REG_BITS)
         ) u_slot (
            .clock          (clock),
            .reset          (reset),
            .clear          (w_squash | w_retire[k]),
            .alloc          (w_alloc[k]),
            .alloc_dest     (w_alloc_dest[k]),
            .complete       (w_complete[k]),
            .complete_value (w_cmp_value[k]),
            .mispredict     (w_mark_mp[k]),
            .busy           (w_busy[k]),
            .done           (w_done[k]),
            .mispred        (w_mispred[k]),
            .dest_idx       (w_dest[k]),
            .value          (w_value[k])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rob_multiway.sv
// ============================================================================
//  Module      : tb_rob_multiway
//  Description : Self-checking bench for rob_multiway (default parameters),
//                table-driven fill plus hand sequences for retire/squash.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_multiway;

   logic         clock = 1'b0;
   logic         reset;
   logic [1:0]   disp_valid;
   logic [9:0]   disp_dest_idx;
   logic [1:0]   disp_avail;
   logic [9:0]   disp_tag;
   logic [1:0]   cdb_valid;
   logic [9:0]   cdb_tag;
   logic [63:0]  cdb_value;
   logic         mispredict_valid;
   logic [4:0]   mispredict_tag;
   logic [1:0]   ret_valid;
   logic [9:0]   ret_dest_idx;
   logic [63:0]  ret_value;
   logic         squash;
   logic [5:0]   count;
   logic         full;
   logic         empty;

   always #5 clock = ~clock;

   rob_multiway dut (
      .clock            (clock),
      .reset            (reset),
      .disp_valid       (disp_valid),
      .disp_dest_idx    (disp_dest_idx),
      .disp_avail       (disp_avail),
      .disp_tag         (disp_tag),
      .cdb_valid        (cdb_valid),
      .cdb_tag          (cdb_tag),
      .cdb_value        (cdb_value),
      .mispredict_valid (mispredict_valid),
      .mispredict_tag   (mispredict_tag),
      .ret_valid        (ret_valid),
      .ret_dest_idx     (ret_dest_idx),
      .ret_value        (ret_value),
      .squash           (squash),
      .count            (count),
      .full             (full),
      .empty            (empty)
   );

   typedef struct {
      logic [4:0]  dest;
      logic [31:0] value;
   } sb_t;

   typedef struct {
      logic [1:0] dv;
      int         avail;
      int         cnt;
   } row_t;

   sb_t         sb [$];
   logic [31:0] exp_val [32];
   row_t        tbl [19];
   int          errors = 0;
   int          checks = 0;
   int          m_tail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr();
      disp_valid       = '0;
      disp_dest_idx    = '0;
      cdb_valid        = '0;
      cdb_tag          = '0;
      cdb_value        = '0;
      mispredict_valid = 1'b0;
      mispredict_tag   = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      clr();
      #1;
   endtask

   task automatic set_cdb(input logic [1:0] cv, input int t0, input int t1);
      cdb_valid = cv;
      cdb_tag   = {5'(t1 % 32), 5'(t0 % 32)};
      cdb_value = {exp_val[t1 % 32], exp_val[t0 % 32]};
   endtask

   // Drives one dispatch cycle; accepted lanes enter the scoreboard in order.
   task automatic disp(input logic [1:0] dv, input logic [4:0] d0, input logic [4:0] d1,
                       input logic [31:0] v0, input logic [31:0] v1, input int exp_avail);
      int  n;
      sb_t e;
      n             = 0;
      disp_valid    = dv;
      disp_dest_idx = {d1, d0};
      #1;
      chk("disp_avail", 64'(disp_avail), 64'(exp_avail));
      for (int i = 0; i < 2; i++) begin
         if (dv[i] && i < exp_avail) begin
            chk("disp_tag", 64'(disp_tag[i*5 +: 5]), 64'((m_tail + i) % 32));
            e.dest  = (i == 1) ? d1 : d0;
            e.value = (i == 1) ? v1 : v0;
            sb.push_back(e);
            exp_val[(m_tail + i) % 32] = e.value;
            n++;
         end
      end
      m_tail = (m_tail + n) % 32;
      tick();
   endtask

   always @(negedge clock) begin
      if (reset === 1'b0 && ret_valid !== 2'b00) begin
         chk("ret_contig", 64'(ret_valid == 2'b10), 64'd0);
         for (int j = 0; j < 2; j++) begin
            if (ret_valid[j]) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ret_unexpected: lane %0d retired dest %0h with nothing outstanding", j, ret_dest_idx[j*5 +: 5]);
               end else begin
                  sb_t e;
                  e = sb.pop_front();
                  chk("ret_dest", 64'(ret_dest_idx[j*5 +: 5]), 64'(e.dest));
                  chk("ret_value", 64'(ret_value[j*32 +: 32]), 64'(e.value));
               end
            end
         end
         if (squash) sb.delete();
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      clr();
      for (int k = 0; k < 32; k++) exp_val[k] = '0;
      tbl[0] = '{2'b11, 2, 2};
      tbl[1] = '{2'b01, 2, 3};
      tbl[2] = '{2'b00, 2, 3};
      tbl[3] = '{2'b11, 2, 5};
      for (int r = 4; r <= 16; r++) tbl[r] = '{2'b11, 2, 5 + 2*(r-3)};
      tbl[17] = '{2'b11, 1, 32};
      tbl[18] = '{2'b01, 0, 32};

      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_ret_valid", 64'(ret_valid), 64'd0);
      chk("rst_squash", 64'(squash), 64'd0);
      chk("rst_disp_avail", 64'(disp_avail), 64'd2);

      // Two-lane dispatch, out-of-order completion, joint retire.
      disp(2'b11, 5'd3, 5'd4, 32'h55, 32'hAA, 2);
      chk("count_after_disp", 64'(count), 64'd2);
      chk("ret_before_cdb", 64'(ret_valid), 64'd0);
      set_cdb(2'b01, 1, 0);
      #1;
      chk("ret_tag1_only", 64'(ret_valid), 64'd0);
      tick();
      chk("ret_after_tag1", 64'(ret_valid), 64'd0);
      set_cdb(2'b01, 0, 0);
      #1;
`ifdef ROB_CDB_BYPASS_EN
      chk("pair_ret_valid", 64'(ret_valid), 64'd3);
      chk("pair_dest", 64'(ret_dest_idx), 64'({5'd4, 5'd3}));
      chk("pair_value", ret_value, {32'hAA, 32'h55});
      tick();
`else
      chk("ret_tag0_same_cycle", 64'(ret_valid), 64'd0);
      tick();
      chk("pair_ret_valid", 64'(ret_valid), 64'd3);
      chk("pair_dest", 64'(ret_dest_idx), 64'({5'd4, 5'd3}));
      chk("pair_value", ret_value, {32'hAA, 32'h55});
      tick();
`endif
      chk("pair_empty", 64'(empty), 64'd1);

      // Fill from head=tail=2 through the wrap to full.
      for (int r = 0; r < 19; r++) begin
         disp(tbl[r].dv, 5'(r), 5'(r + 1), 32'h1000 + 32'(2*r), 32'h1001 + 32'(2*r), tbl[r].avail);
         chk("fill_count", 64'(count), 64'(tbl[r].cnt));
      end
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_avail", 64'(disp_avail), 64'd0);

      set_cdb(2'b11, 2, 3);
      #1;
`ifdef ROB_CDB_BYPASS_EN
      chk("full_ret_valid", 64'(ret_valid), 64'd3);
      chk("full_ret_avail", 64'(disp_avail), 64'd0);
      tick();
`else
      chk("full_ret_early", 64'(ret_valid), 64'd0);
      tick();
      chk("full_ret_valid", 64'(ret_valid), 64'd3);
      chk("full_ret_avail", 64'(disp_avail), 64'd0);
      tick();
`endif
      chk("after_ret_count", 64'(count), 64'd30);
      chk("after_ret_avail", 64'(disp_avail), 64'd2);
      chk("after_ret_full", 64'(full), 64'd0);

      for (int k = 0; k < 15; k++) begin
         set_cdb(2'b11, 4 + 2*k, 5 + 2*k);
         tick();
      end
      tick();
      tick();
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_empty", 64'(empty), 64'd1);

      // Reset in the middle of traffic.
      disp(2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 2);
      reset         = 1'b1;
      disp_valid    = 2'b11;
      disp_dest_idx = {5'd9, 5'd8};
      #1;
      chk("midrst_ret_valid", 64'(ret_valid), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      clr();
      #1;
      sb.delete();
      m_tail = 0;
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_empty", 64'(empty), 64'd1);
      chk("midrst_avail", 64'(disp_avail), 64'd2);

      // Mispredicted branch at tag 1 retires with tag 0 and squashes 2,3.
      disp(2'b11, 5'd10, 5'd11, 32'h100, 32'h101, 2);
      disp(2'b11, 5'd12, 5'd13, 32'h102, 32'h103, 2);
      mispredict_valid = 1'b1;
      mispredict_tag   = 5'd1;
      #1;
      tick();
      set_cdb(2'b11, 2, 3);
      #1;
      tick();
      set_cdb(2'b11, 0, 1);
`ifndef ROB_CDB_BYPASS_EN
      #1;
      chk("sq_not_yet", 64'(squash), 64'd0);
      tick();
      cdb_valid = 2'b11;
      cdb_tag   = {5'd3, 5'd2};
      cdb_value = {32'hDEAD, 32'hBEEF};
`endif
      disp_valid    = 2'b11;
      disp_dest_idx = {5'd21, 5'd20};
      #1;
      chk("sq_squash", 64'(squash), 64'd1);
      chk("sq_ret_valid", 64'(ret_valid), 64'd3);
      chk("sq_dest", 64'(ret_dest_idx), 64'({5'd11, 5'd10}));
      chk("sq_value", ret_value, {32'h101, 32'h100});
      tick();
      chk("sq_pulse_end", 64'(squash), 64'd0);
      chk("sq_count", 64'(count), 64'd0);
      chk("sq_empty", 64'(empty), 64'd1);
      chk("sq_ret_after", 64'(ret_valid), 64'd0);
      m_tail = 0;
      disp(2'b11, 5'd14, 5'd15, 32'h200, 32'h201, 2);
      set_cdb(2'b11, 0, 1);
      tick();
      tick();
      tick();
      chk("post_sq_empty", 64'(empty), 64'd1);

      // Completion-to-retire latency at the head.
      disp(2'b01, 5'd7, 5'd0, 32'h7, 32'h0, 2);
      set_cdb(2'b01, 2, 0);
      #1;
`ifdef ROB_CDB_BYPASS_EN
      chk("lat_ret_valid", 64'(ret_valid), 64'd1);
      chk("lat_ret_value", 64'(ret_value[31:0]), 64'h7);
      tick();
`else
      chk("lat_ret_early", 64'(ret_valid), 64'd0);
      tick();
      chk("lat_ret_valid", 64'(ret_valid), 64'd1);
      chk("lat_ret_value", 64'(ret_value[31:0]), 64'h7);
`endif
      tick();
      chk("lat_empty", 64'(empty), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
